// File: rtl/mac_operand_feeder_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-bit MAC operand feeder.
package mac_operand_feeder_pkg;

  localparam int unsigned MAC_DATA_W  = 4;
  localparam int unsigned MAC_ACC_W   = 8;
  // Frame length shares the accumulator width, so it saturates at 255.
  localparam int unsigned FRAME_LEN_W = MAC_ACC_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } feeder_state_e;

  function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mac_operand_feeder_fifo.sv
// Synchronous FIFO for {last, x, y} operand entries; exposes full, empty and occupancy.
module mac_pair_fifo #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [ADDR_W:0]  count
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the 4-bit MAC: buffers pairs, frames them with a clear pulse and
// a completion pulse, and drives zero operands whenever no pair is issued.
module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_x,
  input  logic [DATA_W-1:0]      in_y,
  input  logic                   in_last,
  input  logic                   run,
  output logic [DATA_W-1:0]      mac_x,
  output logic [DATA_W-1:0]      mac_y,
  output logic                   mac_clr,
  output logic                   mac_vld,
  output logic                   frame_done,
  output logic [FRAME_LEN_W-1:0] frame_len,
  output logic [ADDR_W:0]        fifo_cnt
);

  localparam int unsigned ENTRY_W = 2 * DATA_W + 1;

  logic [ENTRY_W-1:0]     push_data;
  logic [ENTRY_W-1:0]     pop_data;
  logic                   full;
  logic                   empty;
  logic                   pop;
  feeder_state_e          state;
  logic [FRAME_LEN_W-1:0] pair_cnt;

  assign push_data = {in_last, in_x, in_y};
  assign in_ready  = !full;
  assign pop       = (state == STREAM) && run && !empty;

  mac_pair_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mac_x      <= '0;
      mac_y      <= '0;
      mac_clr    <= 1'b0;
      mac_vld    <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      pair_cnt   <= '0;
    end else begin
      // The MAC accumulates every clock, so non-issue cycles must present zeros.
      mac_x      <= '0;
      mac_y      <= '0;
      mac_clr    <= 1'b0;
      mac_vld    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty && run) state <= CLEAR;
        end
        CLEAR: begin
          mac_clr  <= 1'b1;
          pair_cnt <= '0;
          state    <= STREAM;
        end
        STREAM: begin
          if (pop) begin
            mac_x    <= pop_data[2*DATA_W-1:DATA_W];
            mac_y    <= pop_data[DATA_W-1:0];
            mac_vld  <= 1'b1;
            pair_cnt <= sat_inc(pair_cnt);
            if (pop_data[2*DATA_W]) state <= DRAIN;
          end
        end
        DRAIN: begin
          frame_done <= 1'b1;
          frame_len  <= pair_cnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
